// File: rtl/beam_thresh_ctrl.sv
// Threshold staging/load sequencer for the dual-beam trigger array, plus gated
// saturating per-beam trigger scalers with snapshot readout.
module beam_thresh_ctrl #(
  parameter int unsigned NPAIR       = 4,
  parameter int unsigned SCALER_BITS = 16,
  parameter int unsigned GATE_CYCLES = 375000,
  localparam int unsigned NBEAMS     = 2 * NPAIR,
  localparam int unsigned AW         = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_i,
  input  logic [AW-1:0]          addr_i,
  input  logic [17:0]            dat_i,
  output logic                   wr_ack_o,
  input  logic                   commit_i,
  output logic                   busy_o,
  output logic [17:0]            thresh_o,
  output logic [NBEAMS-1:0]      thresh_ce_o,
  output logic                   update_o,
  input  logic [NBEAMS-1:0]      trigger_i,
  input  logic [AW-1:0]          scal_addr_i,
  output logic [SCALER_BITS-1:0] scal_dat_o,
  output logic                   scal_new_o
);

  localparam int unsigned TW = 18;
  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  // Beam DSPs compare against the two's-complement negation of the threshold.
  function automatic logic [TW-1:0] conv(input logic [TW-1:0] t);
    return TW'(TW'(0) - t);
  endfunction

  state_e                 state_q;
  logic [AW-1:0]          idx_q;
  logic [AW-1:0]          idx_nxt;
  logic                   pend_q;
  logic                   busy_q;
  logic                   upd_q;
  logic [TW-1:0]          thresh_q;
  logic [NBEAMS-1:0]      ce_q;
  logic [TW-1:0]          stage_q [NBEAMS];
  logic [TW-1:0]          stage0_fwd;
  logic                   go;

  logic [GW-1:0]          gate_q;
  logic                   gate_last;
  logic [SCALER_BITS-1:0] cnt_q  [NBEAMS];
  logic [SCALER_BITS-1:0] snap_q [NBEAMS];
  logic [SCALER_BITS-1:0] scal_dat_q;
  logic                   scal_new_q;

  assign wr_ack_o    = wr_i & ~rst_i & (state_q == ST_IDLE);
  assign busy_o      = busy_q;
  assign thresh_o    = thresh_q;
  assign thresh_ce_o = ce_q;
  assign update_o    = upd_q;
  assign scal_dat_o  = scal_dat_q;
  assign scal_new_o  = scal_new_q;

  // A write landing in the same cycle as the go must reach beam 0's load.
  always_comb begin
    idx_nxt    = idx_q + AW'(1);
    stage0_fwd = stage_q[0];
    if (wr_ack_o && (addr_i == AW'(0))) begin
      stage0_fwd = dat_i;
    end
    go = commit_i | pend_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        stage_q[b] <= '0;
      end
    end else if (wr_ack_o) begin
      stage_q[addr_i] <= dat_i;
    end
  end

  // Load sequencer: one beam per cycle, then a single update strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      upd_q    <= 1'b0;
      thresh_q <= '0;
      ce_q     <= '0;
    end else begin
      upd_q    <= 1'b0;
      thresh_q <= '0;
      ce_q     <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q  <= ST_LOAD;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b1;
            ce_q     <= NBEAMS'(1);
            thresh_q <= conv(stage0_fwd);
          end
        end
        ST_LOAD: begin
          if (commit_i) begin
            pend_q <= 1'b1;
          end
          if (idx_q == AW'(NBEAMS - 1)) begin
            state_q <= ST_UPDATE;
            upd_q   <= 1'b1;
          end else begin
            idx_q    <= idx_nxt;
            ce_q     <= NBEAMS'(1) << idx_nxt;
            thresh_q <= conv(stage_q[idx_nxt]);
          end
        end
        ST_UPDATE: begin
          if (commit_i) begin
            pend_q <= 1'b1;
          end
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gate_last = (gate_q == GW'(GATE_CYCLES - 1));

  // Free-running gate; terminal cycle's trigger is folded into the snapshot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gate_q     <= '0;
      scal_new_q <= 1'b0;
      scal_dat_q <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        cnt_q[b]  <= '0;
        snap_q[b] <= '0;
      end
    end else begin
      gate_q     <= gate_last ? '0 : gate_q + GW'(1);
      scal_new_q <= gate_last;
      scal_dat_q <= snap_q[scal_addr_i];
      for (int b = 0; b < NBEAMS; b++) begin
        logic [SCALER_BITS-1:0] inc;
        inc = (cnt_q[b] == '1) ? cnt_q[b] : cnt_q[b] + SCALER_BITS'(trigger_i[b]);
        if (gate_last) begin
          snap_q[b] <= inc;
          cnt_q[b]  <= '0;
        end else begin
          cnt_q[b]  <= inc;
        end
      end
    end
  end

endmodule

// File: doc/beam_thresh_ctrl.md
# beam_thresh_ctrl

Control-side companion to the dual-beam trigger cores: stages per-beam unsigned thresholds from a register write port, converts them to the two's-complement form the beam DSPs require, and sequences the shared threshold bus, per-beam load enables and a common update strobe into NPAIR dual-beam instances. It also consumes the beams' trigger outputs and maintains gated, saturating per-beam trigger scalers for rate readout. It sits between the register interface and the beam array in the trigger clock domain.

## Interface
- NPAIR, 4: number of dual-beam instances; NBEAMS = 2*NPAIR, beam b maps to pair b/2, lane b%2.
- SCALER_BITS, 16: scaler counter width.
- GATE_CYCLES, 375000: scaler gate length in clk_i cycles (>= NBEAMS+2).
- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous, active-high reset.
- wr_i  in  1  threshold write request; held until wr_ack_o.
- addr_i  in  clog2(NBEAMS)  beam index for write.
- dat_i  in  18  unsigned threshold value.
- wr_ack_o  out  1  one-cycle write acknowledge.
- commit_i  in  1  pulse: load all staged thresholds into beams.
- busy_o  out  1  load sequence in progress.
- thresh_o  out  18  shared threshold bus to all pairs.
- thresh_ce_o  out  NBEAMS  per-beam load enable, bit 2p+k drives pair p thresh_ce_i[k].
- update_o  out  1  common update strobe to all pairs.
- trigger_i  in  NBEAMS  beam trigger outputs, bit 2p+k from pair p trigger_o[k].
- scal_addr_i  in  clog2(NBEAMS)  scaler read index.
- scal_dat_o  out  SCALER_BITS  snapshot of selected scaler.
- scal_new_o  out  1  one-cycle pulse: new snapshot available.

## Operation
- Staging: NBEAMS 18-bit registers, reset to 0. Write accepted only in IDLE: wr_i high in IDLE -> stage[addr_i] <= dat_i, wr_ack_o high that cycle. Outside IDLE wr_ack_o stays low; wr_i holds.
- Conversion: thresh_o = (2^18 - T) mod 2^18 for staged T (T=0 -> 0; T=1 -> 18'h3FFFF; T=18'h20000 -> 18'h20000).
- FSM IDLE -> LOAD -> UPDATE -> IDLE.
  - IDLE: commit_i (or pending flag) -> LOAD with idx=0. Write and commit in same cycle: write accepted and included in the load.
  - LOAD: one beam per cycle: thresh_o = conv(stage[idx]), thresh_ce_o = one-hot bit idx; idx increments; after idx=NBEAMS-1 -> UPDATE.
  - UPDATE: update_o high one cycle, thresh_ce_o = 0 -> IDLE.
- commit_i while busy: sets pending; one extra full sequence runs from IDLE next cycle. Multiple commits while busy collapse into one.
- Outside LOAD: thresh_ce_o = 0, thresh_o = 0.
- Scalers: per beam, count +1 each cycle trigger_i[b]=1, saturate at 2^SCALER_BITS-1. Gate counter runs 0..GATE_CYCLES-1 freely. In terminal gate cycle: snapshot[b] <= counter[b] + that cycle's trigger (saturated), counters <= 0, scal_new_o high next cycle.
- Readout: scal_dat_o = snapshot[scal_addr_i], registered.
- Reset: FSM IDLE, pending cleared, staging, counters, snapshots, gate counter cleared; all outputs 0. Reset mid-LOAD aborts without update_o; beams keep partial loads unapplied.

## Timing
- Commit accepted at cycle 0 (IDLE): thresh_ce_o bit i high cycle 1+i (i=0..NBEAMS-1); update_o cycle NBEAMS+1; busy_o high cycles 1..NBEAMS+1; IDLE at NBEAMS+2, write acceptable then.
- All outputs registered; thresh_o and thresh_ce_o change together.
- Write ack: same cycle as acceptance (combinational from FSM state registered); staged value visible to a LOAD beginning next cycle.
- Pending rerun: LOAD restarts cycle NBEAMS+3 (one IDLE cycle between sequences).
- scal_dat_o: 1-cycle latency from scal_addr_i. scal_new_o: cycle after terminal gate cycle; snapshot valid that same cycle.

## Test plan
- Reset, write beam 3 = 18'h00100, commit -> cycle 4 thresh_ce_o=8'h08, thresh_o=18'h3FF00; update_o at cycle 9 (NPAIR=4); busy_o low cycle 10.
- Write beam 0 = 0 and beam 1 = 1 -> thresh_o 18'h00000 and 18'h3FFFF on their ce cycles.
- wr_i held from cycle 2 during load -> no wr_ack_o until cycle 10; commit at cycle 3 and 5 -> exactly one extra sequence, two update_o pulses total.
- GATE_CYCLES=16, trigger_i[5] high 10 cycles per gate, including terminal cycle -> scal_new_o pulse, scaler 5 reads 10 one cycle after address; others 0.
- SCALER_BITS=4, trigger_i[0] constantly high, GATE_CYCLES=32 -> snapshot 15 (saturated).
- rst_i at cycle 3 of a load -> no update_o, outputs 0 next cycle, staging cleared; new write+commit loads normally.
